// File: rtl/fetch_buffered.sv
// Buffered instruction fetch: issues in-order requests into a small queue and presents the
// oldest filled entry to Decode; a redirect flushes the queue and drops stale responses.
module fetch_buffered #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrc_E,
  input  logic [XLEN-1:0] PCTarget_E,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            Valid_F,
  input  logic            Ready_D,
  output logic [XLEN-1:0] PC_F,
  output logic [31:0]     Instr_F
);

  localparam int unsigned     PW     = $clog2(DEPTH);
  localparam int unsigned     CW     = PW + 1;
  localparam logic [CW:0]     DepthC = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [31:0]     r_instr [DEPTH];
  logic [PW-1:0]   r_head, r_tail, r_fill;
  // r_pend counts allocated-but-unfilled entries; the head is filled iff r_used > r_pend.
  logic [CW-1:0]   r_used, r_pend, r_drop;
  logic [CW-1:0]   w_used_d, w_pend_d, w_drop_d;
  logic [CW:0]     w_occ, w_outst;
  logic            w_fire, w_deq, w_fill, w_discard;

  assign w_occ   = {1'b0, r_used} + {1'b0, r_drop};
  assign w_outst = {1'b0, r_drop} + {1'b0, r_pend};

  // Gated by rst so no request is presented while reset is held.
  assign imem_req_valid = rst && !PCSrc_E && (w_occ < DepthC);
  assign imem_req_addr  = r_fpc;
  assign w_fire         = imem_req_valid && imem_req_ready;

  assign Valid_F = (r_used > r_pend) && !PCSrc_E;
  assign w_deq   = Valid_F && Ready_D;
  assign PC_F    = r_pc[r_head];
  assign Instr_F = r_instr[r_head];

  assign w_discard = imem_rsp_valid && !PCSrc_E && (r_drop != '0);
  assign w_fill    = imem_rsp_valid && !PCSrc_E && (r_drop == '0) && (r_pend != '0);

  always_comb begin
    w_used_d = r_used;
    w_pend_d = r_pend;
    w_drop_d = r_drop;
    if (PCSrc_E) begin
      w_used_d = '0;
      w_pend_d = '0;
      // A response landing in the redirect cycle retires one outstanding request itself.
      if (imem_rsp_valid && (w_outst != '0)) begin
        w_drop_d = CW'(w_outst - 1'b1);
      end else begin
        w_drop_d = CW'(w_outst);
      end
    end else begin
      w_used_d = r_used + CW'(w_fire) - CW'(w_deq);
      w_pend_d = r_pend + CW'(w_fire) - CW'(w_fill);
      w_drop_d = r_drop - CW'(w_discard);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fpc  <= RESET_PC;
      r_head <= '0;
      r_tail <= '0;
      r_fill <= '0;
      r_used <= '0;
      r_pend <= '0;
      r_drop <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= RESET_PC;
        r_instr[i] <= '0;
      end
    end else begin
      r_used <= w_used_d;
      r_pend <= w_pend_d;
      r_drop <= w_drop_d;
      if (PCSrc_E) begin
        r_fpc  <= {PCTarget_E[XLEN-1:2], 2'b00};
        r_head <= r_tail;
        r_fill <= r_tail;
      end else begin
        if (w_fire) begin
          r_pc[r_tail] <= r_fpc;
          r_tail       <= r_tail + PW'(1);
          r_fpc        <= r_fpc + PcStep;
        end
        if (w_fill) begin
          r_instr[r_fill] <= imem_rsp_data;
          r_fill          <= r_fill + PW'(1);
        end
        if (w_deq) begin
          r_head <= r_head + PW'(1);
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && !PCSrc_E && (r_drop == '0) && (r_pend == '0)))
    else $error("fetch_buffered: response with no outstanding request");

endmodule

// File: tb/tb_fetch_buffered.sv
// Directed bench for fetch_buffered with a latency-programmable in-order memory model.
module tb_fetch_buffered;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrc_E = 1'b0;
  logic [63:0] PCTarget_E = '0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        Valid_F;
  logic        Ready_D = 1'b0;
  logic [63:0] PC_F;
  logic [31:0] Instr_F;

  logic        w_valid_wrap, wv_f_wrap;
  logic [63:0] w_addr_wrap, w_pc_wrap;
  logic [31:0] w_instr_wrap;

  int checks = 0;
  int failures = 0;

  // Memory model: response for a request accepted at edge n is shown mem_sel+1 cycles later.
  logic        mem_ready = 1'b1;
  logic [1:0]  mem_sel = 2'd0;
  logic [3:0]  st_v;
  logic [63:0] st_a [4];
  int          fire_cnt;

  always #5 clk = ~clk;

  fetch_buffered #(.XLEN(64), .DEPTH(4), .RESET_PC(64'h0)) u_dut (
    .clk(clk), .rst(rst), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .Valid_F(Valid_F), .Ready_D(Ready_D),
    .PC_F(PC_F), .Instr_F(Instr_F)
  );

  fetch_buffered #(.XLEN(64), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .PCSrc_E(1'b0), .PCTarget_E(64'h0),
    .imem_req_valid(w_valid_wrap), .imem_req_ready(1'b1),
    .imem_req_addr(w_addr_wrap), .imem_rsp_valid(1'b0),
    .imem_rsp_data(32'h0), .Valid_F(wv_f_wrap), .Ready_D(1'b0),
    .PC_F(w_pc_wrap), .Instr_F(w_instr_wrap)
  );

  assign imem_req_ready = mem_ready;
  assign imem_rsp_valid = st_v[mem_sel];
  assign imem_rsp_data  = {16'hC0DE, st_a[mem_sel][15:0]};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_v     <= '0;
      fire_cnt <= 0;
      for (int i = 0; i < 4; i++) st_a[i] <= '0;
    end else begin
      st_v  <= {st_v[2:0], imem_req_valid && imem_req_ready};
      st_a[0] <= imem_req_addr;
      for (int i = 1; i < 4; i++) st_a[i] <= st_a[i-1];
      if (imem_req_valid && imem_req_ready) fire_cnt <= fire_cnt + 1;
    end
  end

  // Holds reset two cycles, then releases it just after a falling edge (start of cycle 0).
  task automatic start_run(input logic [1:0] sel, input logic rdy);
    rst = 1'b0;
    PCSrc_E = 1'b0;
    mem_sel = sel;
    mem_ready = 1'b1;
    Ready_D = rdy;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0h exp=0", imem_req_valid); end
    if (Valid_F !== 1'b0) begin failures++; $display("FAIL reset_valid_f got=%0h exp=0", Valid_F); end
    if (PC_F !== 64'h0) begin failures++; $display("FAIL reset_pc_f got=%0h exp=0", PC_F); end
    if (Instr_F !== 32'h0) begin failures++; $display("FAIL reset_instr_f got=%0h exp=0", Instr_F); end
    if (imem_req_addr !== 64'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", imem_req_addr); end
    if (w_pc_wrap !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL reset_wrap_pc_f got=%0h exp=fffffffffffffffc", w_pc_wrap); end
  endtask

  task automatic test_wrap;
    start_run(2'd0, 1'b1);
    checks += 3;
    if (w_valid_wrap !== 1'b1) begin failures++; $display("FAIL wrap_first_valid got=%0h exp=1", w_valid_wrap); end
    if (w_addr_wrap !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_first_addr got=%0h exp=fffffffffffffffc", w_addr_wrap); end
    @(negedge clk);
    if (w_addr_wrap !== 64'h0) begin failures++; $display("FAIL wrap_second_addr got=%0h exp=0", w_addr_wrap); end
  endtask

  task automatic test_streaming;
    start_run(2'd0, 1'b1);
    checks += 2;
    if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL stream_first_valid got=%0h exp=1", imem_req_valid); end
    if (imem_req_addr !== 64'h0) begin failures++; $display("FAIL stream_first_addr got=%0h exp=0", imem_req_addr); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks += 2;
      if (Valid_F !== (k >= 2)) begin failures++; $display("FAIL stream_valid_f cyc=%0d got=%0h exp=%0h", k, Valid_F, k >= 2); end
      if (imem_req_addr !== 64'(4 * k)) begin failures++; $display("FAIL stream_addr cyc=%0d got=%0h exp=%0h", k, imem_req_addr, 4 * k); end
      if (k >= 2) begin
        checks += 2;
        if (PC_F !== 64'(4 * (k - 2))) begin failures++; $display("FAIL stream_pc_f cyc=%0d got=%0h exp=%0h", k, PC_F, 4 * (k - 2)); end
        if (Instr_F !== 32'hC0DE_0000 + 32'(4 * (k - 2))) begin failures++; $display("FAIL stream_instr_f cyc=%0d got=%0h exp=%0h", k, Instr_F, 32'hC0DE_0000 + 32'(4 * (k - 2))); end
      end
    end
  endtask

  task automatic test_full_queue;
    start_run(2'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL full_req_valid cyc=%0d got=%0h exp=0", k, imem_req_valid); end
      end
      if (k >= 2) begin
        checks += 3;
        if (Valid_F !== 1'b1) begin failures++; $display("FAIL full_valid_f cyc=%0d got=%0h exp=1", k, Valid_F); end
        if (PC_F !== 64'h0) begin failures++; $display("FAIL full_pc_f cyc=%0d got=%0h exp=0", k, PC_F); end
        if (Instr_F !== 32'hC0DE_0000) begin failures++; $display("FAIL full_instr_hold cyc=%0d got=%0h exp=c0de0000", k, Instr_F); end
      end
    end
    checks++;
    if (fire_cnt !== 4) begin failures++; $display("FAIL full_fire_count got=%0d exp=4", fire_cnt); end
    Ready_D = 1'b1;
    @(negedge clk);
    Ready_D = 1'b0;
    checks += 3;
    if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL full_resume_valid got=%0h exp=1", imem_req_valid); end
    if (PC_F !== 64'h4) begin failures++; $display("FAIL full_deq_pc_f got=%0h exp=4", PC_F); end
    if (Instr_F !== 32'hC0DE_0004) begin failures++; $display("FAIL full_deq_instr got=%0h exp=c0de0004", Instr_F); end
    @(negedge clk);
    checks += 2;
    if (fire_cnt !== 5) begin failures++; $display("FAIL full_refill_count got=%0d exp=5", fire_cnt); end
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL full_refull_valid got=%0h exp=0", imem_req_valid); end
  endtask

  // Reset lands mid-cycle, well away from any rising edge.
  task automatic test_mid_reset;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks += 5;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL midrst_req_valid got=%0h exp=0", imem_req_valid); end
    if (Valid_F !== 1'b0) begin failures++; $display("FAIL midrst_valid_f got=%0h exp=0", Valid_F); end
    if (PC_F !== 64'h0) begin failures++; $display("FAIL midrst_pc_f got=%0h exp=0", PC_F); end
    if (Instr_F !== 32'h0) begin failures++; $display("FAIL midrst_instr_f got=%0h exp=0", Instr_F); end
    if (imem_req_addr !== 64'h0) begin failures++; $display("FAIL midrst_addr got=%0h exp=0", imem_req_addr); end
  endtask

  task automatic test_redirect_inflight;
    start_run(2'd2, 1'b1);
    repeat (3) @(negedge clk);
    PCSrc_E = 1'b1;
    PCTarget_E = 64'h1002;
    #1;
    checks += 2;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_req_valid got=%0h exp=0", imem_req_valid); end
    if (Valid_F !== 1'b0) begin failures++; $display("FAIL redir_valid_f got=%0h exp=0", Valid_F); end
    @(negedge clk);
    PCSrc_E = 1'b0;
    #1;
    checks += 2;
    if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL redir_resume_valid got=%0h exp=1", imem_req_valid); end
    if (imem_req_addr !== 64'h1000) begin failures++; $display("FAIL redir_target_addr got=%0h exp=1000", imem_req_addr); end
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (Valid_F !== 1'b0) begin failures++; $display("FAIL redir_drop_valid_f cyc=%0d got=%0h exp=0", k, Valid_F); end
    end
    @(negedge clk);
    checks += 3;
    if (Valid_F !== 1'b1) begin failures++; $display("FAIL redir_first_valid got=%0h exp=1", Valid_F); end
    if (PC_F !== 64'h1000) begin failures++; $display("FAIL redir_first_pc got=%0h exp=1000", PC_F); end
    if (Instr_F !== 32'hC0DE_1000) begin failures++; $display("FAIL redir_first_instr got=%0h exp=c0de1000", Instr_F); end
    @(negedge clk);
    checks += 2;
    if (PC_F !== 64'h1004) begin failures++; $display("FAIL redir_second_pc got=%0h exp=1004", PC_F); end
    if (Instr_F !== 32'hC0DE_1004) begin failures++; $display("FAIL redir_second_instr got=%0h exp=c0de1004", Instr_F); end
  endtask

  task automatic test_redirect_with_rsp;
    start_run(2'd1, 1'b0);
    repeat (3) @(negedge clk);
    checks += 2;
    if (Valid_F !== 1'b1) begin failures++; $display("FAIL rsp_redir_pre_valid got=%0h exp=1", Valid_F); end
    if (PC_F !== 64'h0) begin failures++; $display("FAIL rsp_redir_pre_pc got=%0h exp=0", PC_F); end
    Ready_D = 1'b1;
    PCSrc_E = 1'b1;
    PCTarget_E = 64'h2000;
    #1;
    checks += 2;
    if (imem_rsp_valid !== 1'b1) begin failures++; $display("FAIL rsp_redir_rsp_present got=%0h exp=1", imem_rsp_valid); end
    if (Valid_F !== 1'b0) begin failures++; $display("FAIL rsp_redir_valid_f got=%0h exp=0", Valid_F); end
    @(negedge clk);
    PCSrc_E = 1'b0;
    #1;
    checks += 2;
    if (imem_req_addr !== 64'h2000) begin failures++; $display("FAIL rsp_redir_addr got=%0h exp=2000", imem_req_addr); end
    if (Valid_F !== 1'b0) begin failures++; $display("FAIL rsp_redir_c4_valid got=%0h exp=0", Valid_F); end
    repeat (2) @(negedge clk);
    checks++;
    if (Valid_F !== 1'b0) begin failures++; $display("FAIL rsp_redir_c6_valid got=%0h exp=0", Valid_F); end
    @(negedge clk);
    checks += 3;
    if (Valid_F !== 1'b1) begin failures++; $display("FAIL rsp_redir_new_valid got=%0h exp=1", Valid_F); end
    if (PC_F !== 64'h2000) begin failures++; $display("FAIL rsp_redir_new_pc got=%0h exp=2000", PC_F); end
    if (Instr_F !== 32'hC0DE_2000) begin failures++; $display("FAIL rsp_redir_new_instr got=%0h exp=c0de2000", Instr_F); end
  endtask

  task automatic test_back_to_back;
    start_run(2'd0, 1'b1);
    repeat (3) @(negedge clk);
    PCSrc_E = 1'b1;
    PCTarget_E = 64'h300;
    @(negedge clk);
    PCTarget_E = 64'h407;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL b2b_req_valid got=%0h exp=0", imem_req_valid); end
    @(negedge clk);
    PCSrc_E = 1'b0;
    #1;
    checks += 2;
    if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL b2b_resume_valid got=%0h exp=1", imem_req_valid); end
    if (imem_req_addr !== 64'h404) begin failures++; $display("FAIL b2b_addr got=%0h exp=404", imem_req_addr); end
    repeat (2) @(negedge clk);
    checks += 3;
    if (Valid_F !== 1'b1) begin failures++; $display("FAIL b2b_valid_f got=%0h exp=1", Valid_F); end
    if (PC_F !== 64'h404) begin failures++; $display("FAIL b2b_pc_f got=%0h exp=404", PC_F); end
    if (Instr_F !== 32'hC0DE_0404) begin failures++; $display("FAIL b2b_instr_f got=%0h exp=c0de0404", Instr_F); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_streaming();
    test_full_queue();
    test_mid_reset();
    test_redirect_inflight();
    test_redirect_with_rsp();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
